fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of mainmem.
- Owns the PC and drives mainmem address/read_write. Captures the combinational data_out word each cycle into a small FIFO.
- Presents {pc, instruction} to the decode stage with a valid/ready handshake.
- Accepts branch/jump redirects from downstream. Flags misaligned or out-of-range fetch addresses.

---
 rtl/fetch_stage.sv | 116 +++++++++++
 tb/tb_fetch_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads mainmem combinationally and buffers
// {pc, word} pairs in a small FIFO for decode. Optional halt on ecall/ebreak: FETCH_HALT_EN.
module fetch_stage #(
    parameter logic [31:0] STARTING_ADDR   = 32'h01000000,
    parameter logic [31:0] MEM_DEPTH_BYTES = 32'h00100000,
    parameter int          FIFO_DEPTH      = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] address,
    output logic        read_write,
    output logic [31:0] data_in,
    input  logic [31:0] data_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fault,
    output logic        halted
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [31:0] pc;
    logic [31:0] mem_pc   [FIFO_DEPTH];
    logic [31:0] mem_inst [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic pc_ok;
    logic redirect_ok;
    logic pop;
    logic has_space;
    logic can_try;
    logic fetch_ok;
    logic fetch_bad;
    logic halt_q;

    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - STARTING_ADDR;
        return (off < MEM_DEPTH_BYTES) && (a[1:0] == 2'b00);
    endfunction

    assign address    = pc;
    assign read_write = 1'b0;
    assign data_in    = 32'h0;

    // Handshake: the head entry transfers on any posedge where inst_valid and inst_ready
    // are both high; inst/inst_pc hold steady while inst_valid=1 and inst_ready=0.
    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? mem_inst[rd_ptr] : 32'h0;
    assign inst_pc    = inst_valid ? mem_pc[rd_ptr]   : 32'h0;
    assign halted     = halt_q;

    assign pc_ok       = in_range(pc);
    assign redirect_ok = in_range(redirect_pc);
    assign pop         = inst_valid & inst_ready;
    assign has_space   = (count < FULL_CNT) | pop;
    assign can_try     = !reset & !redirect_valid & !fault & !halt_q & has_space;
    assign fetch_ok    = can_try & pc_ok;
    assign fetch_bad   = can_try & !pc_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc     <= STARTING_ADDR;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            fault  <= 1'b0;
        end else if (redirect_valid) begin
            // A pop in this cycle is consumed, but everything still buffered is dropped.
            pc     <= redirect_pc;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            if (!redirect_ok)
                fault <= 1'b1;
        end else begin
            if (fetch_ok) begin
                mem_pc[wr_ptr]   <= pc;
                mem_inst[wr_ptr] <= data_out;
                wr_ptr           <= wr_ptr + 1'b1;
                pc               <= pc + 32'd4;
            end
            if (fetch_bad)
                fault <= 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({fetch_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_HALT_EN
    logic halt_word;
    assign halt_word = (data_out == 32'h00000073) || (data_out == 32'h00100073);

    always_ff @(posedge clock) begin
        if (reset)
            halt_q <= 1'b0;
        else if (fetch_ok && halt_word)
            halt_q <= 1'b1;
    end
`else
    assign halt_q = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a behavioural mainmem image feeds data_out, and a
// scoreboard queue holds the {pc, word} entries decode is expected to accept.
module tb_fetch_stage;

    localparam logic [31:0] S     = 32'h01000000;
    localparam logic [31:0] DEPTH = 32'h00100000;

    logic        clock;
    logic        reset;
    logic [31:0] address;
    logic        read_write;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fault;
    logic        halted;

    logic [31:0] image [256];
    logic [63:0] exp_q[$];
    int          checks;
    int          passes;

    fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .address        (address),
        .read_write     (read_write),
        .data_in        (data_in),
        .data_out       (data_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fault          (fault),
        .halted         (halted)
    );

    // Clock and combinational mainmem model
    initial clock = 1'b0;
    always #5 clock = ~clock;
    assign data_out = image[address[9:2]];

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        do w = $urandom; while (w == 32'h00000073 || w == 32'h00100073);
        return w;
    endfunction

    function automatic logic [63:0] ent(input logic [31:0] pc);
        return {pc, image[pc[9:2]]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic push_range(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(ent(first + 32'(4 * i)));
    endtask

    // One clock: score any handshake that will complete at the coming posedge, then advance.
    task automatic tick();
        logic [63:0] e;
        #2;
        if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
            check("pop_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pop_entry", {inst_pc, inst}, e);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc = target;
        tick();
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        reset = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        for (int i = 0; i < 256; i++) image[i] = rand_word();
        image[4] = 32'h00000073;

        // Reset state
        do_reset();
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst", 64'(inst), 64'd0);
        check("rst_inst_pc", 64'(inst_pc), 64'd0);
        check("rst_address", 64'(address), 64'(S));
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("read_write", 64'(read_write), 64'd0);
        check("data_in", 64'(data_in), 64'd0);

        // Streaming with inst_ready=1; word 4 is ecall
        inst_ready = 1'b1;
`ifdef FETCH_HALT_EN
        push_range(S, 5);
        ticks(8);
        check("halt_set", 64'(halted), 64'd1);
        check("halt_address", 64'(address), 64'(S + 32'h14));
        check("halt_drained", 64'(inst_valid), 64'd0);
        redirect(S);
        check("halt_sticky", 64'(halted), 64'd1);
        check("halt_redir_addr", 64'(address), 64'(S));
        ticks(2);
        check("halt_no_fetch", 64'(inst_valid), 64'd0);
`else
        push_range(S, 7);
        ticks(8);
        check("stream_halted", 64'(halted), 64'd0);
        check("stream_address", 64'(address), 64'(S + 32'h20));
        check("stream_head_pc", 64'(inst_pc), 64'(S + 32'h1C));
`endif
        check("stream_sb_empty", 64'(exp_q.size()), 64'd0);
        image[4] = rand_word();

        // Back-pressure: fill to two entries, then drain
        do_reset();
        ticks(5);
        check("bp_valid", 64'(inst_valid), 64'd1);
        check("bp_head", {inst_pc, inst}, ent(S));
        check("bp_address", 64'(address), 64'(S + 32'h8));
        inst_ready = 1'b1;
        push_range(S, 5);
        ticks(5);
        check("bp_sb_empty", 64'(exp_q.size()), 64'd0);
        check("bp_full_head", 64'(inst_pc), 64'(S + 32'h14));
        check("bp_full_addr", 64'(address), 64'(S + 32'h1C));

        // Redirect while full and popping: head consumed, rest flushed
        push_range(S + 32'h14, 1);
        redirect(S + 32'h100);
        check("redir_flush", 64'(inst_valid), 64'd0);
        check("redir_address", 64'(address), 64'(S + 32'h100));
        tick();
        check("redir_head", {inst_pc, inst}, ent(S + 32'h100));
        push_range(S + 32'h100, 3);
        ticks(3);
        check("redir_sb_empty", 64'(exp_q.size()), 64'd0);

        // Misaligned redirect
        do_reset();
        inst_ready = 1'b1;
        redirect(S + 32'h102);
        check("mis_fault", 64'(fault), 64'd1);
        check("mis_address", 64'(address), 64'(S + 32'h102));
        ticks(3);
        check("mis_no_push", 64'(inst_valid), 64'd0);
        check("mis_addr_hold", 64'(address), 64'(S + 32'h102));
        redirect(S);
        check("fault_sticky", 64'(fault), 64'd1);
        check("fault_redir_addr", 64'(address), 64'(S));
        ticks(2);
        check("fault_no_fetch", 64'(inst_valid), 64'd0);
        do_reset();
        check("fault_cleared", 64'(fault), 64'd0);
        check("fault_rst_addr", 64'(address), 64'(S));

        // Aligned but one past the end of memory
        redirect(S + DEPTH);
        check("oor_redirect_fault", 64'(fault), 64'd1);

        // Sequential fetch across the top of memory
        do_reset();
        inst_ready = 1'b1;
        redirect(S + DEPTH - 32'h10);
        check("top_redir_ok", 64'(fault), 64'd0);
        push_range(S + DEPTH - 32'h10, 4);
        ticks(4);
        check("top_last_ok", 64'(fault), 64'd0);
        check("top_next_addr", 64'(address), 64'(S + DEPTH));
        tick();
        check("top_fault", 64'(fault), 64'd1);
        check("top_no_push", 64'(inst_valid), 64'd0);
        tick();
        check("top_addr_hold", 64'(address), 64'(S + DEPTH));
        check("top_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
